key_conditioner: RTL and testbench

- Upstream front end for the 4-bit ALU control unit.
- Turns the raw active-low board push-buttons (KEY[2:0]) into clean, synchronous, single-cycle press pulses: key0_pressed (mode toggle), key1_pressed (execute), key2_pressed (AC).
- Per key: 2-flop synchroniser, counter-based debouncer, edge detector.
- Also exposes debounced level and release pulses for display/diagnostic use.

---
 rtl/key_conditioner.sv | 94 +++++++++
 tb/tb_key_conditioner.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Push-button front end: per-key 2-flop synchroniser, counter debouncer and edge detector.
// Produces registered one-cycle press/release pulses plus the debounced held level.
module key_conditioner #(
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_pressed,
    output logic [NUM_KEYS-1:0] key_released,
    output logic [NUM_KEYS-1:0] key_held
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } keyState_t;

    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;
    logic [NUM_KEYS-1:0] r_pressed;
    logic [NUM_KEYS-1:0] r_released;
    keyState_t           r_state     [NUM_KEYS];
    logic [CNT_W-1:0]    r_cnt       [NUM_KEYS];

    logic [NUM_KEYS-1:0] w_sample;
    logic [NUM_KEYS-1:0] w_pressNext;
    logic [NUM_KEYS-1:0] w_releaseNext;
    keyState_t           w_stateNext [NUM_KEYS];
    logic [CNT_W-1:0]    w_cntNext   [NUM_KEYS];

    // Synchronised sample, inverted so 1 means the button is down.
    assign w_sample = ~r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= '1;
            r_sync2    <= '1;
            r_pressed  <= '0;
            r_released <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                r_state[i] <= RELEASED;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_sync1    <= key_n;
            r_sync2    <= r_sync1;
            r_pressed  <= w_pressNext;
            r_released <= w_releaseNext;
            for (int i = 0; i < NUM_KEYS; i++) begin
                r_state[i] <= w_stateNext[i];
                r_cnt[i]   <= w_cntNext[i];
            end
        end
    end

    // Any agreeing sample clears the count; only an unbroken run of DEBOUNCE_CYCLES flips.
    always_comb begin
        w_pressNext   = '0;
        w_releaseNext = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            w_stateNext[i] = r_state[i];
            w_cntNext[i]   = '0;
            if (w_sample[i] != (r_state[i] == PRESSED)) begin
                if (r_cnt[i] == CNT_LAST) begin
                    if (r_state[i] == PRESSED) begin
                        w_stateNext[i]   = RELEASED;
                        w_releaseNext[i] = 1'b1;
                    end else begin
                        w_stateNext[i] = PRESSED;
                        w_pressNext[i] = 1'b1;
                    end
                end else begin
                    w_cntNext[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        key_held = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            key_held[i] = (r_state[i] == PRESSED);
        end
    end

    assign key_pressed  = r_pressed;
    assign key_released = r_released;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with DEBOUNCE_CYCLES=4: stimulus pushes expected
// pulses (edge index, pressed, released, held); a negedge monitor pops and compares.
module tb_key_conditioner;

    localparam int NK  = 3;
    localparam int DC  = 4;
    localparam int LAT = DC + 2;

    logic          clk;
    logic          rst;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_pressed;
    logic [NK-1:0] key_released;
    logic [NK-1:0] key_held;

    typedef struct {
        int            cyc;
        logic [NK-1:0] pressed;
        logic [NK-1:0] released;
        logic [NK-1:0] held;
    } expPulse_t;

    expPulse_t expQ[$];
    int        edgeCount;
    int        errors;
    int        checks;

    key_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_n        (key_n),
        .key_pressed  (key_pressed),
        .key_released (key_released),
        .key_held     (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges seen so far; read only on falling edges.
    initial edgeCount = 0;
    always @(posedge clk) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, edgeCount);
        end
    endtask

    task automatic pushExpected(input int cyc, input logic [NK-1:0] p, input logic [NK-1:0] r,
                                input logic [NK-1:0] h);
        expPulse_t e;
        e.cyc      = cyc;
        e.pressed  = p;
        e.released = r;
        e.held     = h;
        expQ.push_back(e);
    endtask

    // Drive new raw keys on a falling edge; an accepted change shows LAT edges later.
    task automatic applyStimulus(input logic [NK-1:0] keys, input bit expectPulse,
                                 input logic [NK-1:0] p, input logic [NK-1:0] r,
                                 input logic [NK-1:0] h);
        @(negedge clk);
        key_n = keys;
        if (expectPulse) pushExpected(edgeCount + LAT, p, r, h);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every pulse the DUT shows must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && ((key_pressed | key_released) != '0)) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_pulse", {26'd0, key_pressed, key_released}, 32'd0);
            end else begin
                expPulse_t e;
                e = expQ.pop_front();
                checkOutput("pulse_edge", edgeCount, e.cyc);
                checkOutput("pulse_pressed", {29'd0, key_pressed}, {29'd0, e.pressed});
                checkOutput("pulse_released", {29'd0, key_released}, {29'd0, e.released});
                checkOutput("pulse_held", {29'd0, key_held}, {29'd0, e.held});
            end
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        key_n  = 3'b111;
        waitCycles(2);
        checkOutput("reset_pressed", {29'd0, key_pressed}, 32'd0);
        checkOutput("reset_released", {29'd0, key_released}, 32'd0);
        checkOutput("reset_held", {29'd0, key_held}, 32'd0);
        rst = 1'b0;
        waitCycles(3);

        $display("[TB] clean press and release on key 1");
        applyStimulus(3'b101, 1'b1, 3'b010, 3'b000, 3'b010);
        waitCycles(12);
        checkOutput("held_after_press", {29'd0, key_held}, 32'd2);
        applyStimulus(3'b111, 1'b1, 3'b000, 3'b010, 3'b000);
        waitCycles(10);
        checkOutput("held_after_release", {29'd0, key_held}, 32'd0);

        $display("[TB] three-cycle glitch on key 1");
        applyStimulus(3'b101, 1'b0, '0, '0, '0);
        waitCycles(2);
        applyStimulus(3'b111, 1'b0, '0, '0, '0);
        waitCycles(10);
        checkOutput("held_after_glitch", {29'd0, key_held}, 32'd0);

        $display("[TB] bouncing key 0");
        applyStimulus(3'b110, 1'b0, '0, '0, '0);
        applyStimulus(3'b111, 1'b0, '0, '0, '0);
        applyStimulus(3'b110, 1'b0, '0, '0, '0);
        applyStimulus(3'b111, 1'b0, '0, '0, '0);
        applyStimulus(3'b110, 1'b1, 3'b001, 3'b000, 3'b001);
        waitCycles(12);
        applyStimulus(3'b111, 1'b1, 3'b000, 3'b001, 3'b000);
        waitCycles(10);

        $display("[TB] simultaneous keys 0 and 2");
        applyStimulus(3'b010, 1'b1, 3'b101, 3'b000, 3'b101);
        waitCycles(10);
        checkOutput("held_simultaneous", {29'd0, key_held}, 32'd5);
        applyStimulus(3'b111, 1'b1, 3'b000, 3'b101, 3'b000);
        waitCycles(10);

        $display("[TB] reset mid-debounce on key 2");
        applyStimulus(3'b011, 1'b0, '0, '0, '0);
        waitCycles(4);
        rst = 1'b1;
        waitCycles(1);
        checkOutput("midreset_pressed", {29'd0, key_pressed}, 32'd0);
        checkOutput("midreset_held", {29'd0, key_held}, 32'd0);
        rst = 1'b0;
        pushExpected(edgeCount + LAT, 3'b100, 3'b000, 3'b100);
        waitCycles(14);
        applyStimulus(3'b111, 1'b1, 3'b000, 3'b100, 3'b000);
        waitCycles(10);

        $display("[TB] reset on the flipping edge of key 0");
        applyStimulus(3'b110, 1'b0, '0, '0, '0);
        waitCycles(LAT - 1);
        rst = 1'b1;
        waitCycles(1);
        checkOutput("flipreset_held", {29'd0, key_held}, 32'd0);
        rst = 1'b0;
        pushExpected(edgeCount + LAT, 3'b001, 3'b000, 3'b001);
        waitCycles(14);
        applyStimulus(3'b111, 1'b1, 3'b000, 3'b001, 3'b000);
        waitCycles(10);

        $display("[TB] short press on key 0");
        applyStimulus(3'b110, 1'b0, '0, '0, '0);
        waitCycles(2);
        applyStimulus(3'b111, 1'b0, '0, '0, '0);
        waitCycles(12);
        checkOutput("short_held", {29'd0, key_held}, 32'd0);

        checkOutput("pending_pulses", expQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
